// File: rtl/z80_bus_mem_slave_if.sv
// Z80 CPU bus bundle between a CPU (or bus-functional model) and a memory/IO slave.
//   master : drives the CPU control strobes, address and write data; receives read data and WAIT.
//   slave  : samples the CPU strobes, address and write data; drives read data and WAIT.
// All control strobes are active-low, exactly as they appear on the Z80 pins.
interface z80_bus_mem_slave_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        rfsh_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        wait_n;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
    input  cpu_di, wait_n
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
    output cpu_di, wait_n
  );
endinterface

// File: rtl/z80_bus_mem_slave.sv
// Z80 bus slave: byte RAM, programmable wait states, one decoded OUT-port latch and a
// committed-write counter. Every bus access is committed exactly once, on the enabled edge that
// enters StDone; the FSM then holds until MREQ and IORQ are both released.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clk_enable    : CPU clock enable; bus-side state only advances while high
//   bus           : Z80 pin bundle (slave modport): strobes, A, cpu_dout in; cpu_di, wait_n out
//   io_latch      : last byte written to a matching OUT port
//   io_strobe     : one-clk pulse on the edge io_latch is loaded
//   wr_count      : committed RAM writes, wraps at 16 bits
//   ld_en/ld_addr/ld_data : preload port, writes RAM on every clk edge regardless of clk_enable
module z80_bus_mem_slave #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  IO_MASK     = 8'h01,
  parameter logic [7:0]  IO_MATCH    = 8'h00,
  parameter logic [7:0]  IO_RD_VAL   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  z80_bus_mem_slave_if.slave    bus,
  output logic [7:0]            io_latch,
  output logic                  io_strobe,
  output logic [15:0]           wr_count,
  input  logic                  ld_en,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [7:0]            ld_data
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [2:0]  CntLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wait_q, wait_d;
  logic [7:0]        cpu_di_q, cpu_di_d;
  logic [7:0]        io_latch_q, io_latch_d;
  logic              io_strobe_q, io_strobe_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              mem_we;
  logic              commit;

  logic [7:0]        mem_q [Depth];
  logic [ADDR_W-1:0] addr;

  logic mem_acc, io_acc, inta, access, io_hit;

  // Upper address bits are deliberately ignored (RAM aliases across the 64K space).
  logic unused_addr;
  assign unused_addr = ^bus.A[15:ADDR_W];

  assign addr = bus.A[ADDR_W-1:0];

  // Refresh cycles carry MREQ low but are excluded so they never read, write or wait.
  assign mem_acc = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
  assign io_acc  = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
  assign inta    = !bus.iorq_n && !bus.m1_n;
  assign access  = mem_acc || io_acc || inta;
  assign io_hit  = ((bus.A[7:0] & IO_MASK) == (IO_MATCH & IO_MASK));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    cpu_di_d    = cpu_di_q;
    io_latch_d  = io_latch_q;
    io_strobe_d = 1'b0;
    wr_count_d  = wr_count_q;
    mem_we      = 1'b0;
    commit      = 1'b0;

    if (clk_enable) begin
      unique case (state_q)
        StIdle: begin
          if (access) begin
            // Interrupt acknowledge is answered immediately; wait states apply to mem/IO only.
            if ((WAIT_STATES > 0) && !inta) begin
              state_d = StWait;
              cnt_d   = CntLoad;
              wait_d  = 1'b0;
            end else begin
              state_d = StDone;
              commit  = 1'b1;
            end
          end
        end
        StWait: begin
          wait_d = 1'b0;
          if (cnt_q == 3'd0) begin
            state_d = StDone;
            wait_d  = 1'b1;
            commit  = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StDone: begin
          wait_d = 1'b1;
          if (bus.mreq_n && bus.iorq_n) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          wait_d  = 1'b1;
        end
      endcase

      if (commit) begin
        if (mem_acc && !bus.rd_n) begin
          // Reads the pre-write array, so a same-edge preload is not visible yet.
          cpu_di_d = mem_q[addr];
        end else if (mem_acc && !bus.wr_n) begin
          // A preload on the same edge owns the RAM write port; the bus write is dropped.
          if (!ld_en) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + 16'd1;
          end
        end else if ((io_acc && !bus.rd_n) || inta) begin
          cpu_di_d = IO_RD_VAL;
        end else if (io_acc && !bus.wr_n && io_hit) begin
          io_latch_d  = bus.cpu_dout;
          io_strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      wait_q      <= 1'b1;
      cpu_di_q    <= 8'hFF;
      io_latch_q  <= 8'h00;
      io_strobe_q <= 1'b0;
      wr_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      cpu_di_q    <= cpu_di_d;
      io_latch_q  <= io_latch_d;
      io_strobe_q <= io_strobe_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // RAM is intentionally not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end else if (mem_we) begin
      mem_q[addr] <= bus.cpu_dout;
    end
  end

  assign bus.cpu_di = cpu_di_q;
  assign bus.wait_n = (WAIT_STATES == 0) ? 1'b1 : wait_q;
  assign io_latch   = io_latch_q;
  assign io_strobe  = io_strobe_q;
  assign wr_count   = wr_count_q;

endmodule
